// File: rtl/leaf_refill_feeder.sv
// leaf_refill_feeder
//   Write side of the merger tree's leaf interface. Holds one small
//   first-word-fall-through FIFO per leaf, issues refill requests to the
//   memory read engine for leaves with room for a full burst, and files the
//   returned, leaf-tagged records into those FIFOs for the tree to pop.
//
// Ports
//   i_clk, i_rst            clock (rising edge), async active-high reset
//   i_enable                permits new refill requests
//   o_req_valid/o_req_leaf  refill request toward memory
//   i_req_ready             memory engine accepts the request
//   i_data/i_leaf/i_valid   returned record, its destination leaf, valid
//   o_ready                 feeder accepts returned records
//   o_fifo                  head record of every leaf, leaf k at [DATA_WIDTH*k +: DATA_WIDTH]
//   o_fifo_empty            bit k set when leaf k holds no record
//   i_fifo_read             tree pops the head of leaf k
//   o_err                   sticky protocol error (stray or overflowing beat)
//
// Request FSM
//   state | meaning
//   SCAN  | searching for the first eligible leaf at/after the round-robin pointer
//   REQ   | request presented, holding leaf stable until i_req_ready
module leaf_refill_feeder #(
    parameter int NUM_LEAVES = 128,
    parameter int LEAF_W     = 7,
    parameter int DATA_WIDTH = 128,
    parameter int BURST      = 4,
    parameter int DEPTH      = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_enable,
    output logic                             o_req_valid,
    output logic [LEAF_W-1:0]                o_req_leaf,
    input  logic                             i_req_ready,
    input  logic [DATA_WIDTH-1:0]            i_data,
    input  logic [LEAF_W-1:0]                i_leaf,
    input  logic                             i_valid,
    output logic                             o_ready,
    output logic [DATA_WIDTH*NUM_LEAVES-1:0] o_fifo,
    output logic [NUM_LEAVES-1:0]            o_fifo_empty,
    input  logic [NUM_LEAVES-1:0]            i_fifo_read,
    output logic                             o_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REM_W = $clog2(BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ELIG_MAX = CNT_W'(DEPTH - BURST);
    localparam logic [REM_W-1:0] REM_INIT     = REM_W'(BURST);

    typedef enum logic {SCAN = 1'b0, REQ = 1'b1} state_t;
    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem       [NUM_LEAVES][DEPTH];
    logic [PTR_W-1:0]      wr_ptr    [NUM_LEAVES];
    logic [PTR_W-1:0]      rd_ptr    [NUM_LEAVES];
    logic [CNT_W-1:0]      count     [NUM_LEAVES];
    logic [REM_W-1:0]      remaining [NUM_LEAVES];
    logic [NUM_LEAVES-1:0] pending;
    logic [LEAF_W-1:0]     rr_ptr;
    logic [LEAF_W-1:0]     req_leaf_q;
    logic                  ready_q;
    logic                  err_q;

    logic                  beat;
    logic                  push_ok;
    logic                  handshake;
    logic [NUM_LEAVES-1:0] push;
    logic [NUM_LEAVES-1:0] pop;
    logic [NUM_LEAVES-1:0] eligible;
    logic                  found;
    logic [LEAF_W-1:0]     sel_leaf;
    logic [LEAF_W-1:0]     scan_idx;

    assign beat      = i_valid & ready_q;
    // Full is judged on the pre-pop occupancy; a same-cycle pop does not rescue a full leaf.
    assign push_ok   = pending[i_leaf] && (count[i_leaf] != CNT_FULL);
    assign handshake = (state == REQ) && i_req_ready;

    always_comb begin
        push     = '0;
        pop      = '0;
        eligible = '0;
        for (int k = 0; k < NUM_LEAVES; k++) begin
            push[k]     = beat && push_ok && (i_leaf == LEAF_W'(k));
            pop[k]      = i_fifo_read[k] && (count[k] != '0);
            eligible[k] = i_enable && !pending[k] && (count[k] <= CNT_ELIG_MAX);
        end
    end

    // Rotating priority: index wraps naturally because NUM_LEAVES == 2**LEAF_W.
    always_comb begin
        found    = 1'b0;
        sel_leaf = rr_ptr;
        scan_idx = rr_ptr;
        for (int i = 0; i < NUM_LEAVES; i++) begin
            scan_idx = rr_ptr + LEAF_W'(i);
            if (!found && eligible[scan_idx]) begin
                found    = 1'b1;
                sel_leaf = scan_idx;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_LEAVES; k++) begin
                wr_ptr[k]    <= '0;
                rd_ptr[k]    <= '0;
                count[k]     <= '0;
                remaining[k] <= '0;
            end
            pending <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (beat && !push_ok) begin
                err_q <= 1'b1;
            end
            for (int k = 0; k < NUM_LEAVES; k++) begin
                if (push[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
                end
                count[k] <= count[k] + CNT_W'(push[k]) - CNT_W'(pop[k]);
                // A push needs pending set, a handshake needs it clear, so they never collide.
                if (push[k]) begin
                    remaining[k] <= remaining[k] - REM_W'(1);
                    if (remaining[k] == REM_W'(1)) begin
                        pending[k] <= 1'b0;
                    end
                end else if (handshake && (req_leaf_q == LEAF_W'(k))) begin
                    pending[k]   <= 1'b1;
                    remaining[k] <= REM_INIT;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (beat && push_ok) begin
            mem[i_leaf][wr_ptr[i_leaf]] <= i_data;
        end
    end

    always_comb begin
        o_fifo       = '0;
        o_fifo_empty = '0;
        for (int k = 0; k < NUM_LEAVES; k++) begin
            o_fifo_empty[k] = (count[k] == '0);
            o_fifo[DATA_WIDTH*k +: DATA_WIDTH] = (count[k] != '0) ? mem[k][rd_ptr[k]] : '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= SCAN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SCAN: if (found)       state_nxt = REQ;
            REQ:  if (i_req_ready) state_nxt = SCAN;
            default:               state_nxt = SCAN;
        endcase
    end

    always_comb begin
        o_req_valid = (state == REQ);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            req_leaf_q <= '0;
            rr_ptr     <= '0;
        end else begin
            if ((state == SCAN) && found) begin
                req_leaf_q <= sel_leaf;
            end
            if (handshake) begin
                rr_ptr <= req_leaf_q + LEAF_W'(1);
            end
        end
    end

    assign o_req_leaf = req_leaf_q;
    assign o_ready    = ready_q;
    assign o_err      = err_q;
endmodule

// File: tb/tb_leaf_refill_feeder.sv
module tb_leaf_refill_feeder;
    localparam int NL    = 128;
    localparam int LW    = 7;
    localparam int DW    = 128;
    localparam int BURST = 4;
    localparam int DEPTH = 8;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b0;
    logic           i_enable = 1'b0;
    logic           i_req_ready = 1'b0;
    logic           i_valid = 1'b0;
    logic [DW-1:0]  i_data = '0;
    logic [LW-1:0]  i_leaf = '0;
    logic [NL-1:0]  i_fifo_read = '0;
    logic           o_req_valid;
    logic [LW-1:0]  o_req_leaf;
    logic           o_ready;
    logic           o_err;
    logic [DW*NL-1:0] o_fifo;
    logic [NL-1:0]  o_fifo_empty;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: per-leaf queues plus request bookkeeping.
    logic [DW-1:0] m_q [NL][$];
    bit  m_pend [NL];
    int  m_rem  [NL];
    int  m_ptr;
    bit  m_in_req;
    int  m_req_leaf;
    bit  m_ready;
    bit  m_err;

    int  hs_cnt;
    int  hs_dup;
    bit  hs_seen [NL];

    leaf_refill_feeder #(
        .NUM_LEAVES(NL), .LEAF_W(LW), .DATA_WIDTH(DW), .BURST(BURST), .DEPTH(DEPTH)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
        .o_req_valid(o_req_valid), .o_req_leaf(o_req_leaf), .i_req_ready(i_req_ready),
        .i_data(i_data), .i_leaf(i_leaf), .i_valid(i_valid), .o_ready(o_ready),
        .o_fifo(o_fifo), .o_fifo_empty(o_fifo_empty), .i_fifo_read(i_fifo_read),
        .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NL; k++) begin
            m_q[k].delete();
            m_pend[k] = 1'b0;
            m_rem[k]  = 0;
        end
        m_ptr = 0; m_in_req = 1'b0; m_req_leaf = 0; m_ready = 1'b0; m_err = 1'b0;
    endtask

    // Applies one clock edge worth of behaviour, using the inputs currently driven.
    task automatic model_step();
        bit found;
        int sel;
        bit pop_ok [NL];
        int l;
        if (!i_rst && o_req_valid && i_req_ready) begin
            hs_cnt++;
            if (hs_seen[o_req_leaf]) hs_dup++;
            hs_seen[o_req_leaf] = 1'b1;
        end
        if (i_rst) begin
            model_reset();
            return;
        end
        found = 1'b0;
        sel   = 0;
        if (!m_in_req) begin
            for (int i = 0; i < NL; i++) begin
                int k;
                k = (m_ptr + i) % NL;
                if (!found && i_enable && !m_pend[k] && (DEPTH - m_q[k].size()) >= BURST) begin
                    found = 1'b1;
                    sel   = k;
                end
            end
        end
        for (int k = 0; k < NL; k++) pop_ok[k] = i_fifo_read[k] && (m_q[k].size() > 0);
        if (i_valid && m_ready) begin
            l = int'(i_leaf);
            if (m_pend[l] && m_q[l].size() < DEPTH) begin
                m_q[l].push_back(i_data);
                m_rem[l]--;
                if (m_rem[l] == 0) m_pend[l] = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
        for (int k = 0; k < NL; k++) if (pop_ok[k]) void'(m_q[k].pop_front());
        if (m_in_req) begin
            if (i_req_ready) begin
                m_pend[m_req_leaf] = 1'b1;
                m_rem[m_req_leaf]  = BURST;
                m_ptr    = (m_req_leaf + 1) % NL;
                m_in_req = 1'b0;
            end
        end else if (found) begin
            m_in_req   = 1'b1;
            m_req_leaf = sel;
        end
        m_ready = 1'b1;
    endtask

    task automatic compare_all();
        logic [NL-1:0] exp_empty;
        logic [DW-1:0] exp_head;
        check("req_valid", o_req_valid, m_in_req);
        check("req_leaf", o_req_leaf, m_req_leaf);
        check("ready", o_ready, m_ready);
        check("err", o_err, m_err);
        for (int k = 0; k < NL; k++) exp_empty[k] = (m_q[k].size() == 0);
        check("empty_vec", o_fifo_empty, exp_empty);
        for (int k = 0; k < NL; k++) begin
            exp_head = (m_q[k].size() > 0) ? m_q[k][0] : '0;
            check("head", o_fifo[k*DW +: DW], exp_head);
        end
    endtask

    task automatic step();
        model_step();
        @(negedge i_clk);
        compare_all();
    endtask

    task automatic idle();
        i_valid = 1'b0;
        i_fifo_read = '0;
    endtask

    task automatic do_reset();
        #2;
        i_rst = 1'b1;
        #1;
        check("rst_empty", o_fifo_empty, {NL{1'b1}});
        check("rst_req_valid", o_req_valid, 1'b0);
        check("rst_ready", o_ready, 1'b0);
        check("rst_err", o_err, 1'b0);
        check("rst_fifo_or", |o_fifo, 1'b0);
        model_reset();
        idle();
        i_enable = 1'b0;
        i_req_ready = 1'b0;
        step();
        step();
        i_rst = 1'b0;
        step();
    endtask

    initial begin
        logic [DW-1:0] exp1 [$];
        logic [DW-1:0] exp2 [$];
        logic [DW-1:0] d;
        int seq [8] = '{1, 2, 2, 1, 1, 2, 1, 2};
        int cand [$];

        #1 i_rst = 1'b1;
        model_reset();
        @(negedge i_clk);
        compare_all();
        step();
        i_rst = 1'b0;
        step();

        // Free-running requests with no data returns.
        hs_cnt = 0; hs_dup = 0;
        for (int k = 0; k < NL; k++) hs_seen[k] = 1'b0;
        i_enable = 1'b1; i_req_ready = 1'b1;
        repeat (2*NL + 10) step();
        check("a_req_count", hs_cnt, NL);
        check("a_req_dup", hs_dup, 0);
        check("a_idle", o_req_valid, 1'b0);

        // Single burst to leaf 3, then drain it.
        do_reset();
        i_enable = 1'b1; i_req_ready = 1'b1;
        for (int c = 0; c < 40 && !m_pend[3]; c++) step();
        check("b_leaf3_requested", m_pend[3], 1'b1);
        for (int j = 0; j < 4; j++) begin
            i_valid = 1'b1; i_leaf = 3; i_data = DW'(32'hA + j);
            step();
            if (j == 0) begin
                check("b_empty3_fall", o_fifo_empty[3], 1'b0);
                check("b_head_first", o_fifo[3*DW +: DW], 128'hA);
            end
        end
        idle();
        for (int j = 0; j < 4; j++) begin
            check("b_pop_head", o_fifo[3*DW +: DW], 128'hA + j);
            i_fifo_read[3] = 1'b1;
            step();
        end
        idle();
        check("b_empty3_rise", o_fifo_empty[3], 1'b1);

        // Memory stalls while leaf 7 is requested.
        do_reset();
        i_enable = 1'b1; i_req_ready = 1'b1;
        for (int c = 0; c < 40 && !(m_in_req && m_req_leaf == 7); c++) step();
        check("c_valid7", o_req_valid, 1'b1);
        check("c_leaf7", o_req_leaf, 7);
        i_req_ready = 1'b0;
        repeat (5) begin
            step();
            check("c_hold_valid", o_req_valid, 1'b1);
            check("c_hold_leaf", o_req_leaf, 7);
        end
        i_req_ready = 1'b1;
        step();
        check("c_after_hs", o_req_valid, 1'b0);
        step();
        check("c_next_leaf", o_req_leaf, 8);

        // Leaf 0 filled to DEPTH, no pops: must not be requested until room returns.
        do_reset();
        i_enable = 1'b1; i_req_ready = 1'b1;
        for (int c = 0; c < 700; c++) begin
            i_valid = m_pend[0];
            i_leaf  = 0;
            i_data  = rand_data();
            step();
        end
        idle();
        check("d_no_request", o_req_valid, 1'b0);
        check("d_leaf0_full", m_q[0].size(), DEPTH);
        check("d_leaf0_nonempty", o_fifo_empty[0], 1'b0);
        for (int j = 0; j < 4; j++) begin
            i_fifo_read[0] = 1'b1;
            step();
        end
        idle();
        step();
        check("d_req_valid", o_req_valid, 1'b1);
        check("d_req_leaf", o_req_leaf, 0);

        // Stray beat for leaf 9.
        do_reset();
        i_valid = 1'b1; i_leaf = 9; i_data = rand_data();
        step();
        idle();
        check("e_err", o_err, 1'b1);
        check("e_empty9", o_fifo_empty[9], 1'b1);
        i_enable = 1'b1; i_req_ready = 1'b1;
        repeat (5) step();
        check("e_err_sticky", o_err, 1'b1);
        do_reset();

        // Interleaved bursts for leaves 1 and 2, with a same-cycle push/pop on leaf 1.
        i_enable = 1'b1; i_req_ready = 1'b1;
        for (int c = 0; c < 40 && !(m_pend[1] && m_pend[2]); c++) step();
        check("f_both_pending", m_pend[1] && m_pend[2], 1'b1);
        i_enable = 1'b0;
        for (int c = 0; c < 10 && m_in_req; c++) step();
        for (int j = 0; j < 8; j++) begin
            d = rand_data();
            i_valid = 1'b1; i_leaf = LW'(seq[j]); i_data = d;
            i_fifo_read = '0;
            if (j == 4) begin
                i_fifo_read[1] = 1'b1;
                void'(exp1.pop_front());
            end
            if (seq[j] == 1) exp1.push_back(d);
            else exp2.push_back(d);
            step();
        end
        idle();
        check("f_err", o_err, 1'b0);
        while (exp1.size() > 0) begin
            d = exp1.pop_front();
            check("f_leaf1_order", o_fifo[1*DW +: DW], d);
            i_fifo_read[1] = 1'b1;
            step();
        end
        idle();
        check("f_leaf1_empty", o_fifo_empty[1], 1'b1);
        while (exp2.size() > 0) begin
            d = exp2.pop_front();
            check("f_leaf2_order", o_fifo[2*DW +: DW], d);
            i_fifo_read[2] = 1'b1;
            step();
        end
        idle();
        check("f_leaf2_empty", o_fifo_empty[2], 1'b1);
        // Partial burst, then reset mid-burst.
        i_enable = 1'b1; i_req_ready = 1'b1;
        for (int c = 0; c < 40 && !m_pend[3]; c++) step();
        i_enable = 1'b0;
        repeat (2) begin
            i_valid = 1'b1; i_leaf = 3; i_data = rand_data();
            step();
        end
        idle();
        check("f_partial_held", o_fifo_empty[3], 1'b0);
        do_reset();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            i_enable    = ($urandom_range(0, 9) != 0);
            i_req_ready = ($urandom_range(0, 2) != 0);
            i_valid     = 1'b0;
            i_data      = rand_data();
            cand.delete();
            for (int k = 0; k < NL; k++) if (m_pend[k]) cand.push_back(k);
            if (cand.size() > 0 && $urandom_range(0, 9) < 7) begin
                i_valid = 1'b1;
                i_leaf  = LW'(cand[$urandom_range(0, cand.size() - 1)]);
            end
            for (int k = 0; k < NL; k++) i_fifo_read[k] = ($urandom_range(0, 3) == 0);
            step();
        end
        idle();
        step();
        check("g_no_err", o_err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
